// File: rtl/hazard_unit_pkg.sv
// Shared types for the ID/EX hazard controller: FSM state encodings, the
// bundled control-output struct and the load-use compare helper.
package hazard_unit_pkg;

  localparam int unsigned CNT_W = 3;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_FLUSH      = 2'd2,
    HZ_ILLEGAL    = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_stall;
    logic ex_mem_stall;
  } hz_ctrl_t;

  // r0 is hard-wired to zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_f(
    input logic             ex_mem_read,
    input logic [REG_W-1:0] ex_reg_dest,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt,
    input logic             id_uses_rs,
    input logic             id_uses_rt
  );
    logic rs_hit;
    logic rt_hit;
    rs_hit = id_uses_rs && (id_rs == ex_reg_dest);
    rt_hit = id_uses_rt && (id_rt == ex_reg_dest);
    return ex_mem_read && (ex_reg_dest != '0) && (rs_hit || rt_hit);
  endfunction

endpackage

// File: rtl/hazard_unit_hz_down_counter.sv
// 3-bit down-counter with load/decrement/hold and zero detect.
// Load wins over decrement; decrement saturates at zero.
module hz_down_counter
  import hazard_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_unit.sv
// ID/EX hazard controller: load-use stall, taken-branch flush and memory-busy
// freeze. Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_reg_dest,
  input  logic             branch_taken_EX,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic [1:0]       hazard_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_flush_cycles
`endif
);

  localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  hz_state_e        state_q;
  hz_state_e        state_d;
  hz_ctrl_t         ctrl;
  logic             load_use;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             last_cycle;

  assign load_use = load_use_f(ex_mem_read, ex_reg_dest, id_rs, id_rt,
                               id_uses_rs, id_uses_rt);

  // A zero count inside a multi-cycle state also exits, so the FSM cannot wedge.
  assign last_cycle = (cnt == CNT_W'(1)) || cnt_zero;

  hz_down_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    ctrl         = '0;
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    if (mem_busy) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
    end else begin
      unique case (state_q)
        HZ_RUN: begin
          // The ID instruction is squashed by a redirect, so its load-use is moot.
          if (branch_taken_EX) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d      = HZ_FLUSH;
              cnt_load     = 1'b1;
              cnt_load_val = FLUSH_RELOAD;
            end
          end else if (load_use) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d      = HZ_LOAD_STALL;
              cnt_load     = 1'b1;
              cnt_load_val = LOAD_RELOAD;
            end
          end
        end
        HZ_LOAD_STALL: begin
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_stall  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          cnt_dec           = 1'b1;
          if (last_cycle) state_d = HZ_RUN;
        end
        HZ_FLUSH: begin
          ctrl.if_id_flush = 1'b1;
          cnt_dec          = 1'b1;
          if (last_cycle) state_d = HZ_RUN;
        end
        default: begin
          state_d = HZ_RUN;
        end
      endcase
    end
    if (!rst_n) begin
      ctrl = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign id_ex_stall  = ctrl.id_ex_stall;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign hazard_state = rst_n ? state_q : 2'd0;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (ctrl.pc_stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (ctrl.if_id_flush && (perf_flush_q != 32'hFFFF_FFFF)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_cycles = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench: two hazard_unit instances (1/1 and 3/2 stall/flush cycles)
// share one stimulus stream; each step checks both against hand-computed vectors.
module tb_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_reg_dest;
  logic       id_uses_rs, id_uses_rt, ex_mem_read, branch_taken_EX, mem_busy;

  logic       pc_a, ifs_a, iff_a, bub_a, ids_a, exs_a;
  logic [1:0] hs_a;
  logic       pc_b, ifs_b, iff_b, bub_b, ids_b, exs_b;
  logic [1:0] hs_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] pst_a, pfl_a, pst_b, pfl_b;
`endif

  int checks   = 0;
  int failures = 0;

  // Vector layout: {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_stall, ex_mem_stall, hazard_state}
  localparam logic [7:0] IDLE   = 8'b000000_00;
  localparam logic [7:0] LU_RUN = 8'b110100_00;
  localparam logic [7:0] LU_LS  = 8'b110100_01;
  localparam logic [7:0] BR_RUN = 8'b001100_00;
  localparam logic [7:0] FL_FL  = 8'b001000_10;
  localparam logic [7:0] MB_RUN = 8'b110011_00;
  localparam logic [7:0] MB_LS  = 8'b110011_01;

  wire [7:0] obs_a = {pc_a, ifs_a, iff_a, bub_a, ids_a, exs_a, hs_a};
  wire [7:0] obs_b = {pc_b, ifs_b, iff_b, bub_b, ids_b, exs_b, hs_b};

  hazard_unit #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_reg_dest(ex_reg_dest),
    .branch_taken_EX(branch_taken_EX), .mem_busy(mem_busy),
    .pc_stall(pc_a), .if_id_stall(ifs_a), .if_id_flush(iff_a),
    .id_ex_bubble(bub_a), .id_ex_stall(ids_a), .ex_mem_stall(exs_a),
    .hazard_state(hs_a)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(pst_a), .perf_flush_cycles(pfl_a)
`endif
  );

  hazard_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_reg_dest(ex_reg_dest),
    .branch_taken_EX(branch_taken_EX), .mem_busy(mem_busy),
    .pc_stall(pc_b), .if_id_stall(ifs_b), .if_id_flush(iff_b),
    .id_ex_bubble(bub_b), .id_ex_stall(ids_b), .ex_mem_stall(exs_b),
    .hazard_state(hs_b)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(pst_b), .perf_flush_cycles(pfl_b)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic mr, input logic [4:0] dest, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urs, input logic urt,
                       input logic br, input logic mb);
    ex_mem_read     = mr;
    ex_reg_dest     = dest;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rs      = urs;
    id_uses_rt      = urt;
    branch_taken_EX = br;
    mem_busy        = mb;
  endtask

  task automatic drive_idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check both instances mid-cycle, then advance past the next rising edge.
  task automatic step(input string tag, input logic [7:0] exp_a, input logic [7:0] exp_b);
    @(negedge clk);
    chk({tag, "_a"}, obs_a, exp_a);
    chk({tag, "_b"}, obs_b, exp_b);
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic chk_perf(input string tag);
    logic [127:0] obs;
    @(negedge clk);
    obs = {pst_a, pfl_a, pst_b, pfl_b};
    checks++;
    assert (obs === 128'd0) else begin
      failures++;
      $error("FAIL %s observed=%h expected=0", tag, obs);
    end
  endtask
`endif

  initial begin
    // Reset with a live load-use pattern on the inputs: outputs must stay 0.
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rst0", IDLE, IDLE);
    step("rst1", IDLE, IDLE);
    rst_n = 1'b1;
    drive_idle();
    step("idle", IDLE, IDLE);
`ifdef HAZARD_PERF_EN
    chk_perf("perf_after_reset");
`endif

    // Load to r5, ID reads rs=5
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_detect", LU_RUN, LU_RUN);
    drive_idle();
    step("lu_c1", IDLE, LU_LS);
    step("lu_c2", IDLE, LU_LS);
    step("lu_done", IDLE, IDLE);

    // Non-hazards: r0, unused rt, rs mismatch, not a load
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("r0_dest", IDLE, IDLE);
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rt_unused", IDLE, IDLE);
    drive(1'b1, 5'd5, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rs_mismatch", IDLE, IDLE);
    drive(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step("not_load", IDLE, IDLE);

    // Hazard through rt (store data path)
    drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rt_detect", LU_RUN, LU_RUN);
    drive_idle();
    step("rt_c1", IDLE, LU_LS);
    step("rt_c2", IDLE, LU_LS);
    step("rt_done", IDLE, IDLE);

    // Taken branch coincident with load-use: branch wins
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("br_lu", BR_RUN, BR_RUN);
    drive_idle();
    step("br_flush", IDLE, FL_FL);
    step("br_done", IDLE, IDLE);

    // mem_busy for 4 cycles in LOAD_STALL with cnt=2
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("mb_detect", LU_RUN, LU_RUN);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("mb_hold%0d", i), MB_RUN, MB_LS);
    end
    drive_idle();
    step("mb_rel1", IDLE, LU_LS);
    step("mb_rel2", IDLE, LU_LS);
    step("mb_done", IDLE, IDLE);

    // mem_busy outranks a branch in RUN; no flush follows
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("mb_br", MB_RUN, MB_RUN);
    drive_idle();
    step("mb_br_after", IDLE, IDLE);

    // Reset during FLUSH
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rf_branch", BR_RUN, BR_RUN);
    drive_idle();
    rst_n = 1'b0;
    step("rf_reset", IDLE, IDLE);
    rst_n = 1'b1;
    step("rf_after", IDLE, IDLE);

    // Reset during LOAD_STALL abandons the remaining stall cycles
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rl_detect", LU_RUN, LU_RUN);
    drive_idle();
    rst_n = 1'b0;
    step("rl_reset", IDLE, IDLE);
    rst_n = 1'b1;
    step("rl_after1", IDLE, IDLE);
    step("rl_after2", IDLE, IDLE);
`ifdef HAZARD_PERF_EN
    chk_perf("perf_after_midreset");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
